// File: rtl/matrix_pkg.sv
// Shared types and glyph tables for the irrigation status matrix.
// Pure declarations: no latency and no backpressure apply.
package matrix_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_SPRINKLER = 2'b01,
    MODE_DRIPPER   = 2'b10,
    MODE_ERROR     = 2'b11
  } mode_e;

  localparam int MATRIX_COLS = 5;
  localparam int MATRIX_ROWS = 7;
  localparam int HALF_COLS   = (MATRIX_COLS + 1) / 2;
  localparam int H_W         = (HALF_COLS > 1) ? $clog2(HALF_COLS) : 1;

  typedef logic [HALF_COLS-1:0][MATRIX_ROWS-1:0] img_t;

  // Concatenated as {h2, h1, h0}; bit 0 of each entry is the top row.
  localparam img_t IMG_OFF          = {7'h00, 7'h00, 7'h00};
  localparam img_t IMG_SPRINKLER_P0 = {7'h46, 7'h61, 7'h7F};
  localparam img_t IMG_DRIPPER_P0   = {7'h30, 7'h7C, 7'h7E};
  localparam img_t IMG_ERROR_P0     = {7'h14, 7'h22, 7'h41};
  localparam img_t IMG_SPRINKLER_P1 = {7'h40, 7'h60, 7'h78};
  localparam img_t IMG_DRIPPER_P1   = {7'h30, 7'h7C, 7'h7C};
  localparam img_t IMG_ERROR_P1     = {7'h00, 7'h00, 7'h00};

endpackage

// File: rtl/half_column_rom.sv
// Half-column glyph lookup by mode, |column - centre| and animation phase.
// Combinational (zero latency); no backpressure.
module half_column_rom
  import matrix_pkg::*;
(
  input  mode_e                  mode,
  input  logic [H_W-1:0]         h,
  input  logic                   phase,
  output logic [MATRIX_ROWS-1:0] row_data
);

  img_t img;

  always_comb begin
    img = IMG_OFF;
    case (mode)
      MODE_SPRINKLER: img = phase ? IMG_SPRINKLER_P1 : IMG_SPRINKLER_P0;
      MODE_DRIPPER:   img = phase ? IMG_DRIPPER_P1   : IMG_DRIPPER_P0;
      MODE_ERROR:     img = phase ? IMG_ERROR_P1     : IMG_ERROR_P0;
      default:        img = IMG_OFF;
    endcase
    row_data = (int'(h) < HALF_COLS) ? img[h] : '0;
  end

endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Column-multiplexed LED matrix driver; col_sel/row_data are registered and change on a column tick.
// Modes are taken via valid/ready into one pending slot (ready low while full) and applied at frame wrap; IRRIGATION_MATRIX_ANIM_EN adds phase animation.
module irrigation_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int COLS        = MATRIX_COLS,
  parameter int ROWS        = MATRIX_ROWS,
  parameter int SCAN_DIV    = 1000,
  parameter int ANIM_FRAMES = 25,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode_in,
  input  logic            mode_valid,
  output logic            mode_ready,
  output logic [COLS-1:0] col_sel,
  output logic [ROWS-1:0] row_data,
  output logic            frame_start
);

  localparam int PW  = $clog2(SCAN_DIV);
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MID = (COLS - 1) / 2;
  localparam logic [COLS-1:0] COL0    = COLS'(1);
  localparam logic [COLS-1:0] COL_INV = {COLS{ACTIVE_LOW != 0}};
  localparam logic [ROWS-1:0] ROW_INV = {ROWS{ACTIVE_LOW != 0}};

  if (SCAN_DIV < 2 || COLS % 2 != 1 || COLS != MATRIX_COLS || ROWS != MATRIX_ROWS || ANIM_FRAMES < 1)
  begin : g_param_check
    $error("irrigation_matrix_scanner: illegal parameterisation");
  end

  logic [PW-1:0]  pre_q;
  logic [CW-1:0]  col_q, col_nxt;
  logic [H_W-1:0] h_nxt;
  logic [ROWS-1:0] img;
  mode_e act_q, pend_q, mode_nxt;
  logic  pend_vld_q, tick, wrap, accept, phase_nxt;

  assign tick       = (pre_q == PW'(SCAN_DIV - 1));
  assign wrap       = tick && (col_q == CW'(COLS - 1));
  assign mode_ready = !pend_vld_q;
  assign accept     = mode_valid && mode_ready;
  assign col_nxt    = wrap ? '0 : col_q + 1'b1;

  // A pending mode wins at the wrap; otherwise a same-cycle acceptance goes straight to active.
  always_comb begin
    mode_nxt = act_q;
    if (wrap) begin
      if (pend_vld_q)  mode_nxt = pend_q;
      else if (accept) mode_nxt = mode_e'(mode_in);
    end
  end

  always_comb begin
    if (int'(col_nxt) >= MID) h_nxt = H_W'(int'(col_nxt) - MID);
    else                      h_nxt = H_W'(MID - int'(col_nxt));
  end

`ifdef IRRIGATION_MATRIX_ANIM_EN
  localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  logic [FW-1:0] fcnt_q;
  logic          phase_q, restart;

  assign restart = (mode_nxt != act_q) || (fcnt_q == FW'(ANIM_FRAMES - 1));

  always_comb begin
    phase_nxt = phase_q;
    if (wrap) begin
      if (mode_nxt != act_q)                    phase_nxt = 1'b0;
      else if (fcnt_q == FW'(ANIM_FRAMES - 1))  phase_nxt = !phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      fcnt_q  <= restart ? '0 : fcnt_q + 1'b1;
      phase_q <= phase_nxt;
    end
  end
`else
  assign phase_nxt = 1'b0;
`endif

  half_column_rom u_rom (
    .mode     (mode_nxt),
    .h        (h_nxt),
    .phase    (phase_nxt),
    .row_data (img)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      col_q       <= '0;
      act_q       <= MODE_OFF;
      pend_q      <= MODE_OFF;
      pend_vld_q  <= 1'b0;
      col_sel     <= COL0 ^ COL_INV;
      row_data    <= ROW_INV;
      frame_start <= 1'b0;
    end else begin
      pre_q       <= tick ? '0 : pre_q + 1'b1;
      frame_start <= wrap;
      if (tick) begin
        col_q    <= col_nxt;
        col_sel  <= (COL0 << col_nxt) ^ COL_INV;
        row_data <= img ^ ROW_INV;
      end
      if (wrap) begin
        act_q      <= mode_nxt;
        pend_vld_q <= 1'b0;
      end else if (accept) begin
        pend_q     <= mode_e'(mode_in);
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irrigation_matrix_scanner.sv
// Bench for irrigation_matrix_scanner: directed scenarios plus random mode traffic against a timeline model.
module tb_irrigation_matrix_scanner;

  localparam int COLS        = 5;
  localparam int ROWS        = 7;
  localparam int SCAN_DIV    = 4;
  localparam int ANIM_FRAMES = 2;
  localparam int ACTIVE_LOW  = 0;
  localparam int FRAME       = COLS * SCAN_DIV;
  localparam int MID         = (COLS - 1) / 2;
  localparam int CMASK       = ACTIVE_LOW ? (1 << COLS) - 1 : 0;
  localparam int RMASK       = ACTIVE_LOW ? (1 << ROWS) - 1 : 0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      mode_in = 2'b00;
  logic            mode_valid = 1'b0;
  logic            mode_ready;
  logic [COLS-1:0] col_sel;
  logic [ROWS-1:0] row_data;
  logic            frame_start;

  always #5 clk = ~clk;

  irrigation_matrix_scanner #(
    .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV),
    .ANIM_FRAMES(ANIM_FRAMES), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .mode_valid(mode_valid),
    .mode_ready(mode_ready), .col_sel(col_sel), .row_data(row_data),
    .frame_start(frame_start)
  );

  // Glyphs indexed [mode][h]; mode order off, sprinkler, dripper, error.
  int img0 [4][3] = '{'{0, 0, 0}, '{'h7F, 'h61, 'h46}, '{'h7E, 'h7C, 'h30}, '{'h41, 'h22, 'h14}};
  int img1 [4][3] = '{'{0, 0, 0}, '{'h78, 'h60, 'h40}, '{'h7C, 'h7C, 'h30}, '{0, 0, 0}};

  int n_chk = 0;
  int n_err = 0;
  // Model: k = clock edges since reset release; frames_since_change drives the animation phase.
  int k, m_act, m_pend, fsc;
  bit m_pvld;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_rows();
    int c  = (k / SCAN_DIV) % COLS;
    int h  = (c > MID) ? c - MID : MID - c;
    int ph = 0;
`ifdef IRRIGATION_MATRIX_ANIM_EN
    ph = (fsc / ANIM_FRAMES) % 2;
`endif
    return ph ? img1[m_act][h] : img0[m_act][h];
  endfunction

  task automatic check_all();
    int c = (k / SCAN_DIV) % COLS;
    chk_eq("col_sel", int'(col_sel), (1 << c) ^ CMASK);
    chk_eq("row_data", int'(row_data), exp_rows() ^ RMASK);
    chk_eq("frame_start", int'(frame_start), int'(k > 0 && k % FRAME == 0));
    chk_eq("mode_ready", int'(mode_ready), int'(!m_pvld));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, then check at the next falling edge.
  task automatic cycle(input bit v, input int m);
    bit acc;
    mode_valid = v;
    mode_in    = 2'(m);
    acc        = v && !m_pvld;
    @(posedge clk);
    k++;
    if (k % FRAME == 0) begin
      int nm = m_pvld ? m_pend : (acc ? m : m_act);
      fsc    = (nm != m_act) ? 0 : fsc + 1;
      m_act  = nm;
      m_pvld = 1'b0;
    end else if (acc) begin
      m_pend = m;
      m_pvld = 1'b1;
    end
    @(negedge clk);
    mode_valid = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    mode_valid = 1'b0;
    #1;
    chk_eq("rst_col_sel", int'(col_sel), 1 ^ CMASK);
    chk_eq("rst_row_data", int'(row_data), RMASK);
    chk_eq("rst_mode_ready", int'(mode_ready), 1);
    chk_eq("rst_frame_start", int'(frame_start), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    k      = 0;
    m_act  = 0;
    m_pend = 0;
    m_pvld = 1'b0;
    fsc    = 0;
    check_all();
  endtask

  task automatic run_to(input int pos);
    while (k % FRAME != pos) cycle(0, 0);
  endtask

  // Starting at a frame boundary, compare one whole frame against literal glyph values.
  task automatic check_frame(input string tag, input int h0, input int h1, input int h2);
    int hv[3] = '{h0, h1, h2};
    for (int i = 0; i < FRAME; i++) begin
      int c = i / SCAN_DIV;
      int h = (c > MID) ? c - MID : MID - c;
      chk_eq(tag, int'(row_data) ^ RMASK, hv[h]);
      cycle(0, 0);
    end
  endtask

  initial begin
    #2;
    do_reset();

    // Sprinkler accepted mid-frame, applied at the next wrap.
    cycle(0, 0);
    cycle(1, 1);
    chk_eq("spr_pending_rdy", int'(mode_ready), 0);
    run_to(0);
    check_frame("scan_spr", 'h7F, 'h61, 'h46);

    // Dripper requested at column 2 while sprinkler is showing.
    run_to(2 * SCAN_DIV);
    cycle(1, 2);
    chk_eq("drip_rdy_low", int'(mode_ready), 0);
    run_to(0);
    chk_eq("drip_frame_start", int'(frame_start), 1);
    check_frame("scan_drip", 'h7E, 'h7C, 'h30);

    // Error accepted in the wrap cycle itself.
    run_to(FRAME - 1);
    cycle(1, 3);
    chk_eq("collide_rdy", int'(mode_ready), 1);
    check_frame("scan_err", 'h41, 'h22, 'h14);

    // Animation over four sprinkler frames.
    cycle(1, 1);
    run_to(0);
    check_frame("anim_f0", 'h7F, 'h61, 'h46);
    check_frame("anim_f1", 'h7F, 'h61, 'h46);
`ifdef IRRIGATION_MATRIX_ANIM_EN
    check_frame("anim_f2", 'h78, 'h60, 'h40);
    check_frame("anim_f3", 'h78, 'h60, 'h40);
`else
    check_frame("anim_f2", 'h7F, 'h61, 'h46);
    check_frame("anim_f3", 'h7F, 'h61, 'h46);
`endif

    // Reset while a mode sits in the pending slot.
    cycle(1, 2);
    chk_eq("hs_pending_rdy", int'(mode_ready), 0);
    #2;
    do_reset();
    check_frame("post_rst_off", 0, 0, 0);
    check_frame("post_rst_off2", 0, 0, 0);

    // Random mode traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #3;
        do_reset();
      end
      cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
